// File: rtl/lib_switchblock_pkg.sv
// Shared constants and types for the switching-block tree and the DEM element driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lib_switchblock_pkg;

    localparam int INPUT_WIDTH    = 4;
    localparam int NUM_LEAVES     = 8;
    localparam int ELEMS_PER_LEAF = 4;
    localparam int NUM_ELEMS      = NUM_LEAVES * ELEMS_PER_LEAF;
    localparam int COUNT_WIDTH    = $clog2(NUM_ELEMS + 1);

    // Driver output timing state: NRZ holds the pattern, RTZ alternates DRIVE/ZERO.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRIVE = 2'd2,
        ZERO  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/dwa_leaf_selector.sv
// One leaf of the DEM driver: clamps the leaf code and rotates a thermometer over the leaf's elements (DWA).
// Latency: enables are combinational from the current pointer; the pointer updates on the advance strobe.
// Backpressure: none; the parent only strobes advance on accepted samples.
module dwa_leaf_selector #(
    parameter int INPUT_WIDTH    = 4,
    parameter int ELEMS_PER_LEAF = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INPUT_WIDTH-1:0]    code,
    input  logic                      advance,
    output logic [ELEMS_PER_LEAF-1:0] enables,
    output logic                      ovf
);

    localparam int PW = $clog2(ELEMS_PER_LEAF);
    localparam int VW = $clog2(ELEMS_PER_LEAF + 1);
    localparam logic [INPUT_WIDTH-1:0] MAX_CODE = INPUT_WIDTH'(ELEMS_PER_LEAF);

    logic [PW-1:0] ptr;
    logic [VW-1:0] level;
    logic [PW-1:0] offset;

    // Clamp the code to the number of elements; anything larger is flagged.
    assign ovf   = (code > MAX_CODE);
    assign level = ovf ? VW'(ELEMS_PER_LEAF) : VW'(code);

    // Element e is on when its distance past the pointer (mod E) is below the level.
    always_comb begin
        enables = '0;
        offset  = '0;
        for (int e = 0; e < ELEMS_PER_LEAF; e++) begin
            offset     = PW'(e) - ptr;
            enables[e] = (VW'(offset) < level);
        end
    end

    // Pointer moves past the elements just used; a full or empty level wraps to itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr + PW'(level);
        end
    end

endmodule

// File: rtl/dem_element_driver.sv
// Final DEM DAC stage: maps leaf codes to DWA-rotated unit-element enables with NRZ or RTZ timing.
// Latency: 1 cycle from accepted sample to elem_o/elem_count_o/elem_valid_o.
// Backpressure: ready_o drops during the RTZ drive cycle, on a mode change, and during reset.
module dem_element_driver #(
    parameter int INPUT_WIDTH    = lib_switchblock_pkg::INPUT_WIDTH,
    parameter int NUM_LEAVES     = lib_switchblock_pkg::NUM_LEAVES,
    parameter int ELEMS_PER_LEAF = lib_switchblock_pkg::ELEMS_PER_LEAF
) (
    input  logic                                              clk_i,
    input  logic                                              reset_i,
    input  logic [NUM_LEAVES*INPUT_WIDTH-1:0]                 leaf_i,
    input  logic                                              valid_i,
    output logic                                              ready_o,
    input  logic                                              rtz_en_i,
    input  logic                                              ovf_clr_i,
    output logic [NUM_LEAVES*ELEMS_PER_LEAF-1:0]              elem_o,
    output logic                                              elem_valid_o,
    output logic [$clog2(NUM_LEAVES*ELEMS_PER_LEAF+1)-1:0]    elem_count_o,
    output logic                                              ovf_o
);

    import lib_switchblock_pkg::*;

    localparam int NE = NUM_LEAVES * ELEMS_PER_LEAF;
    localparam int CW = $clog2(NE + 1);

    drv_state_t             state;
    drv_state_t             state_d;
    logic                   ready_c;
    logic                   accept;
    logic                   mode_mismatch;
    logic                   any_ovf;
    logic [NUM_LEAVES-1:0]  leaf_ovf;
    logic [NE-1:0]          pattern;
    logic [NE-1:0]          elem_d;
    logic [CW-1:0]          count_d;

    for (genvar k = 0; k < NUM_LEAVES; k++) begin : g_leaf
        dwa_leaf_selector #(
            .INPUT_WIDTH   (INPUT_WIDTH),
            .ELEMS_PER_LEAF(ELEMS_PER_LEAF)
        ) u_leaf (
            .clk    (clk_i),
            .reset  (reset_i),
            .code   (leaf_i[k*INPUT_WIDTH +: INPUT_WIDTH]),
            .advance(accept),
            .enables(pattern[k*ELEMS_PER_LEAF +: ELEMS_PER_LEAF]),
            .ovf    (leaf_ovf[k])
        );
    end

    assign any_ovf = |leaf_ovf;
    assign ready_o = ready_c;

    // Next state, handshake and next output pattern; a mode change forces a pass through IDLE.
    always_comb begin
        state_d       = state;
        ready_c       = 1'b0;
        mode_mismatch = 1'b0;
        accept        = 1'b0;
        elem_d        = '0;
        count_d       = '0;

        case (state)
            IDLE: begin
                ready_c = 1'b1;
            end
            HOLD: begin
                mode_mismatch = rtz_en_i;
                ready_c       = ~rtz_en_i;
            end
            DRIVE: begin
                mode_mismatch = ~rtz_en_i;
                ready_c       = 1'b0;
            end
            ZERO: begin
                mode_mismatch = ~rtz_en_i;
                ready_c       = rtz_en_i;
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase

        if (reset_i) begin
            ready_c = 1'b0;
        end
        accept = valid_i & ready_c;

        if (mode_mismatch) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = rtz_en_i ? DRIVE : HOLD;
        end else if (state == DRIVE) begin
            state_d = ZERO;
        end

        if (accept) begin
            elem_d = pattern;
        end else if (state_d == HOLD) begin
            elem_d = elem_o;
        end

        for (int i = 0; i < NE; i++) begin
            count_d = count_d + CW'(elem_d[i]);
        end
    end

    // Output and state registers; an overflow in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state        <= IDLE;
            elem_o       <= '0;
            elem_count_o <= '0;
            elem_valid_o <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            state        <= state_d;
            elem_o       <= elem_d;
            elem_count_o <= count_d;
            elem_valid_o <= accept;
            ovf_o        <= (accept & any_ovf) | (ovf_o & ~ovf_clr_i);
        end
    end

endmodule

// File: tb/tb_dem_element_driver.sv
// Bench for the DEM element driver: directed steps plus random traffic against a rule-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dem_element_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] leaf;
    logic        valid;
    logic        ready;
    logic        rtz;
    logic        clr;
    logic [31:0] elem;
    logic        elem_valid;
    logic [5:0]  elem_count;
    logic        ovf;

    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference state: per-leaf pointers, the current timing phase, and the expected outputs.
    // Phase: 0 = idle, 1 = NRZ holding, 2 = RTZ driving, 3 = RTZ zero.
    int          m_ptr[8];
    int          m_ph;
    logic [31:0] m_elem;
    logic        m_vld;
    logic        m_ovf;

    dem_element_driver dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .leaf_i      (leaf),
        .valid_i     (valid),
        .ready_o     (ready),
        .rtz_en_i    (rtz),
        .ovf_clr_i   (clr),
        .elem_o      (elem),
        .elem_valid_o(elem_valid),
        .elem_count_o(elem_count),
        .ovf_o       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int code);
        for (int k = 0; k < 8; k++) leaf[k*4 +: 4] = 4'(code);
    endtask

    function automatic logic model_ready();
        if (reset) return 1'b0;
        case (m_ph)
            0:       return 1'b1;
            1:       return ~rtz;
            2:       return 1'b0;
            default: return rtz;
        endcase
    endfunction

    // Check the handshake, advance the model by one edge, then check the registered outputs.
    task automatic tick();
        logic        rdy;
        logic        acc;
        logic        mism;
        logic        anyo;
        logic [31:0] pat;
        int          code;
        int          lvl;
        #1;
        rdy = model_ready();
        check("ready", ready, rdy);
        if (reset) begin
            for (int k = 0; k < 8; k++) m_ptr[k] = 0;
            m_ph   = 0;
            m_elem = '0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            acc  = valid & rdy;
            mism = (m_ph == 1 && rtz) || ((m_ph == 2 || m_ph == 3) && !rtz);
            if (acc) begin
                pat  = '0;
                anyo = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    code = int'(leaf[k*4 +: 4]);
                    lvl  = (code > 4) ? 4 : code;
                    if (code > 4) anyo = 1'b1;
                    for (int i = 0; i < lvl; i++) pat[k*4 + (m_ptr[k] + i) % 4] = 1'b1;
                    m_ptr[k] = (m_ptr[k] + lvl) % 4;
                end
                m_elem = pat;
                m_vld  = 1'b1;
                m_ph   = rtz ? 2 : 1;
                if (anyo) m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
            end else begin
                m_vld = 1'b0;
                if (mism) begin
                    m_ph   = 0;
                    m_elem = '0;
                end else if (m_ph == 2) begin
                    m_ph   = 3;
                    m_elem = '0;
                end
                if (clr) m_ovf = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("elem", elem, m_elem);
        check("elem_valid", elem_valid, m_vld);
        check("elem_count", elem_count, $countones(m_elem));
        check("ovf", ovf, m_ovf);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) m_ptr[k] = 0;
        m_ph   = 0;
        m_elem = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        reset  = 1'b1;
        leaf   = '0;
        valid  = 1'b0;
        rtz    = 1'b0;
        clr    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_elem", elem, 32'h0);
        check("rst_count", elem_count, 6'd0);
        reset = 1'b0;

        // NRZ, every leaf at 1: leaf 0 walks one element per sample
        set_all(1);
        valid = 1'b1;
        tick();
        check("nrz1_a", elem[3:0], 4'b0001);
        check("nrz1_cnt", elem_count, 6'd8);
        tick();
        check("nrz1_b", elem[3:0], 4'b0010);
        tick();
        check("nrz1_c", elem[3:0], 4'b0100);
        check("nrz1_vld", elem_valid, 1'b1);

        // Leaf 0 = 3 twice from a fresh pointer, then 1 to expose the pointer
        reset = 1'b1;
        valid = 1'b0;
        tick();
        reset = 1'b0;
        leaf = '0;
        leaf[3:0] = 4'd3;
        valid = 1'b1;
        tick();
        check("dwa3_a", elem[3:0], 4'b0111);
        tick();
        check("dwa3_b", elem[3:0], 4'b1011);
        leaf[3:0] = 4'd1;
        tick();
        check("dwa3_ptr", elem[3:0], 4'b0100);

        // Overflow: clamp, stickiness, set beats clear, clear alone
        leaf = '0;
        leaf[11:8] = 4'd7;
        tick();
        check("ovf_clamp", elem[11:8], 4'b1111);
        check("ovf_set", ovf, 1'b1);
        valid = 1'b0;
        tick();
        check("ovf_sticky", ovf, 1'b1);
        valid = 1'b1;
        clr = 1'b1;
        leaf[11:8] = 4'd5;
        tick();
        check("ovf_set_wins", ovf, 1'b1);
        valid = 1'b0;
        tick();
        check("ovf_cleared", ovf, 1'b0);
        clr = 1'b0;

        // NRZ hold while valid is low
        reset = 1'b1;
        tick();
        reset = 1'b0;
        leaf = '0;
        leaf[3:0] = 4'd1;
        valid = 1'b1;
        tick();
        check("hold_first", elem[3:0], 4'b0001);
        valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_keep", elem[3:0], 4'b0001);
            check("hold_vld", elem_valid, 1'b0);
        end
        valid = 1'b1;
        tick();
        check("hold_next", elem[3:0], 4'b0010);

        // RTZ with valid held: mode change passes through idle, then drive/zero alternate
        set_all(2);
        rtz = 1'b1;
        tick();
        check("mode_chg_elem", elem, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rtz_drive_cnt", elem_count, 6'd16);
            check("rtz_drive_rdy", ready, 1'b0);
            tick();
            check("rtz_zero_cnt", elem_count, 6'd0);
            check("rtz_zero_rdy", ready, 1'b1);
        end

        // Reset in the middle of a drive cycle
        tick();
        check("rtz_pre_rst", elem_count, 6'd16);
        reset = 1'b1;
        tick();
        check("rst_drive_elem", elem, 32'h0);
        check("rst_drive_vld", elem_valid, 1'b0);
        reset = 1'b0;
        rtz = 1'b0;
        leaf = '0;
        leaf[3:0] = 4'd1;
        tick();
        check("rst_ptr_clear", elem[3:0], 4'b0001);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) rtz = ~rtz;
            for (int k = 0; k < 8; k++) leaf[k*4 +: 4] = 4'($urandom_range(0, 5));
            clr   = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dem_element_driver.md
Name: dem_element_driver

Overview:
- Final registered stage of the DEM DAC, directly downstream of the three-layer switching-block tree.
- Takes the 8 leaf codes and maps each to a thermometer enable vector over ELEMS_PER_LEAF unit elements.
- Within each leaf, element selection rotates by data-weighted averaging (DWA) to first-order shape residual in-leaf mismatch.
- Supports NRZ or return-to-zero (RTZ) output timing, with a valid/ready handshake and a sticky overflow flag.

Parameters:
- INPUT_WIDTH, lib_switchblock_pkg::INPUT_WIDTH (4): width of each leaf code.
- NUM_LEAVES, 8: number of leaf codes; fixed by the 3-layer tree.
- ELEMS_PER_LEAF, 4: unit elements per leaf; power of two, at least 2.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- leaf_i  in  NUM_LEAVES*INPUT_WIDTH  leaf codes; leaf k occupies [k*INPUT_WIDTH +: INPUT_WIDTH], leaf 0 is tree output 3_1
- valid_i  in  1  leaf_i valid
- ready_o  out  1  block can accept a sample this cycle
- rtz_en_i  in  1  1 = RTZ timing, 0 = NRZ
- ovf_clr_i  in  1  clears ovf_o
- elem_o  out  NUM_LEAVES*ELEMS_PER_LEAF  unit-element enables; leaf k element e is bit k*ELEMS_PER_LEAF+e
- elem_valid_o  out  1  elem_o holds a freshly accepted sample
- elem_count_o  out  clog2(NUM_LEAVES*ELEMS_PER_LEAF+1)  popcount of elem_o
- ovf_o  out  1  sticky flag: a leaf code exceeded ELEMS_PER_LEAF

Behaviour:
- Reset (synchronous, takes priority over everything):
  - elem_o, elem_valid_o, elem_count_o, ovf_o = 0.
  - All DWA pointers = 0; state = IDLE.
  - ready_o = 0 in the reset cycle, 1 from the first cycle after reset deasserts.
- Accept: a sample is accepted on a rising edge where valid_i & ready_o = 1.
  - Latency 1: elem_o, elem_count_o and elem_valid_o = 1 appear the next cycle, all registered together.
- Clamping: v = min(leaf code, ELEMS_PER_LEAF). If any leaf code exceeds ELEMS_PER_LEAF in an accepted sample, ovf_o = 1 the next cycle.
- ovf_o is sticky until ovf_clr_i. If a clear and a new overflow occur in the same cycle, set wins.
- DWA per leaf, pointer p in 0..E-1:
  - Enable elements (p+i) mod E for i = 0..v-1.
  - p_next = (p+v) mod E.
  - v = 0: no elements enabled, p unchanged.
  - v = E: all elements enabled, p unchanged.
  - Pointers advance only on accepted samples.
- FSM states:
  - IDLE: elem_o = 0, ready_o = 1. Accept -> HOLD if rtz_en_i = 0, else DRIVE.
  - HOLD (NRZ): elem_o keeps the last pattern, ready_o = 1. Accept -> HOLD with the new pattern. No accept -> stays HOLD, elem_valid_o = 0.
  - DRIVE (RTZ): elem_o = pattern, ready_o = 0 for exactly 1 cycle, always -> ZERO.
  - ZERO (RTZ): elem_o = 0, elem_count_o = 0, elem_valid_o = 0, ready_o = 1. Accept -> DRIVE. No accept -> ZERO.
- Mode change: rtz_en_i is sampled at each edge. If it differs from the current state's mode (HOLD vs DRIVE/ZERO), the next state is IDLE and elem_o = 0 for that cycle. No sample is accepted on that edge; ready_o = 0 in the cycle the mismatch is present. Pointers are retained.
- Mid-operation reset discards all state, including a DRIVE in progress.
- elem_count_o always equals popcount(elem_o) in the same cycle.

Decomposition:
- lib_switchblock_pkg gains:
  - NUM_LEAVES, ELEMS_PER_LEAF
  - NUM_ELEMS = NUM_LEAVES*ELEMS_PER_LEAF
  - COUNT_WIDTH
  - driver state enum typedef (IDLE, HOLD, DRIVE, ZERO)
- Sub-module dwa_leaf_selector, instantiated NUM_LEAVES times via generate:
  - Owns one pointer, the clamp, the overflow detect and the rotated thermometer.
  - Inputs: code, advance strobe. Outputs: enables, ovf.
- Top level holds the FSM, the output registers, the popcount and ovf_o.

Test Plan:
- Reset release, NRZ, all leaves = 1, valid_i = 1 for 3 cycles -> leaf0 bits [3:0] = 0001, 0010, 0100; elem_count_o = 8 each cycle; elem_valid_o = 1.
- NRZ, leaf0 = 3 twice -> [3:0] = 0111, then 1011 (elements 3, 0, 1); final pointer = 2.
- leaf2 = 7 -> [11:8] = 1111 and ovf_o = 1 next cycle. Later, ovf_clr_i together with another overflow -> ovf_o stays 1. ovf_clr_i alone -> 0.
- RTZ, valid_i held 1, all leaves = 2 -> elem_o alternates pattern/0, elem_count_o alternates 16/0, ready_o alternates 0/1; one sample accepted every 2 cycles.
- NRZ, valid_i = 0 for 3 cycles after leaf0 = 1 -> elem_o holds 0001, elem_valid_o = 0. The next leaf0 = 1 sample gives 0010.
- reset_i asserted during DRIVE -> next cycle all outputs 0. Post-reset leaf0 = 1 -> 0001, confirming the pointer was cleared.
